// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the ALU request arbiter: ALU command encodings,
// flag bit positions, arbiter FSM states and the multiply-latency helper.
package alu_pkg;

  localparam int CMD_W = 4;

  // Arithmetic commands (MODE=1)
  localparam logic [CMD_W-1:0] ADD          = 4'd0;
  localparam logic [CMD_W-1:0] SUB          = 4'd1;
  localparam logic [CMD_W-1:0] ADD_CIN      = 4'd2;
  localparam logic [CMD_W-1:0] SUB_CIN      = 4'd3;
  localparam logic [CMD_W-1:0] INC_A        = 4'd4;
  localparam logic [CMD_W-1:0] DEC_A        = 4'd5;
  localparam logic [CMD_W-1:0] INC_B        = 4'd6;
  localparam logic [CMD_W-1:0] DEC_B        = 4'd7;
  localparam logic [CMD_W-1:0] CMP          = 4'd8;
  localparam logic [CMD_W-1:0] INC_MUL      = 4'd9;
  localparam logic [CMD_W-1:0] SHL1_A_MUL_B = 4'd10;

  // Logical commands (MODE=0)
  localparam logic [CMD_W-1:0] LOG_AND  = 4'd0;
  localparam logic [CMD_W-1:0] LOG_NAND = 4'd1;
  localparam logic [CMD_W-1:0] LOG_OR   = 4'd2;
  localparam logic [CMD_W-1:0] LOG_NOR  = 4'd3;
  localparam logic [CMD_W-1:0] LOG_XOR  = 4'd4;
  localparam logic [CMD_W-1:0] LOG_XNOR = 4'd5;

  // Bit positions inside the 6-bit ALU flag vector
  localparam int ERR   = 5;
  localparam int OFLOW = 4;
  localparam int COUT  = 3;
  localparam int G     = 2;
  localparam int E     = 1;
  localparam int L     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  // Multiply commands take the longer ALU latency
  function automatic logic is_mul(input logic mode, input logic [CMD_W-1:0] cmd);
    return mode && ((cmd == INC_MUL) || (cmd == SHL1_A_MUL_B));
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bundle of requester, ALU-side and response signals of the arbiter.
// slave = arbiter side, master = requesters / ALU / response consumer.
interface alu_req_arbiter_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic [1:0]     REQ_VALID;
  logic [1:0]     REQ_READY;
  logic [N-1:0]   REQ0_OPA;
  logic [N-1:0]   REQ0_OPB;
  logic [N-1:0]   REQ1_OPA;
  logic [N-1:0]   REQ1_OPB;
  logic [M-1:0]   REQ0_CMD;
  logic [M-1:0]   REQ1_CMD;
  logic [3:0]     REQ0_CTL;
  logic [3:0]     REQ1_CTL;

  logic [N-1:0]   ALU_OPA;
  logic [N-1:0]   ALU_OPB;
  logic [M-1:0]   ALU_CMD;
  logic           ALU_MODE;
  logic           ALU_CIN;
  logic           ALU_CE;
  logic [1:0]     ALU_INP_VALID;
  logic [2*N-1:0] ALU_RES;
  logic [5:0]     ALU_FLAGS;

  logic           RSP_VALID;
  logic           RSP_READY;
  logic           RSP_ID;
  logic [2*N-1:0] RSP_RES;
  logic [5:0]     RSP_FLAGS;

  modport slave (
    input  REQ_VALID, REQ0_OPA, REQ0_OPB, REQ1_OPA, REQ1_OPB,
           REQ0_CMD, REQ1_CMD, REQ0_CTL, REQ1_CTL,
           ALU_RES, ALU_FLAGS, RSP_READY,
    output REQ_READY, ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN,
           ALU_CE, ALU_INP_VALID, RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS
  );

  modport master (
    output REQ_VALID, REQ0_OPA, REQ0_OPB, REQ1_OPA, REQ1_OPB,
           REQ0_CMD, REQ1_CMD, REQ0_CTL, REQ1_CTL,
           ALU_RES, ALU_FLAGS, RSP_READY,
    input  REQ_READY, ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN,
           ALU_CE, ALU_INP_VALID, RSP_VALID, RSP_ID, RSP_RES, RSP_FLAGS
  );
endinterface

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that did not win
// last time gets the grant; last_grant resets to 1 so requester 0 wins first.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  // Pick the winner and compute the new last-grant on an accepted grant
  always_comb begin
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
    last_grant_d = last_grant_q;
    if (advance && (|grant)) begin
      last_grant_d = grant[1];
    end
  end

  // Remember who won the last accepted grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters. One operation is in flight at a
// time: accept -> ISSUE -> WAIT (ALU latency) -> RESP until drained.
// Optional statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int LAT     = 2,
  parameter int MUL_LAT = 3
) (
  input logic              CLK,
  input logic              RST,
  alu_req_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      GRANT_CNT0,
  output logic [15:0]      GRANT_CNT1,
  output logic [15:0]      ERR_CNT
`endif
);

  localparam int CNT_W = 4;

  arb_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           id_q, id_d;
  logic [N-1:0]   alu_opa_q, alu_opa_d;
  logic [N-1:0]   alu_opb_q, alu_opb_d;
  logic [M-1:0]   alu_cmd_q, alu_cmd_d;
  logic           alu_mode_q, alu_mode_d;
  logic           alu_cin_q, alu_cin_d;
  logic           alu_ce_q, alu_ce_d;
  logic [1:0]     alu_inp_valid_q, alu_inp_valid_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic [2*N-1:0] rsp_res_q, rsp_res_d;
  logic [5:0]     rsp_flags_q, rsp_flags_d;

  logic [1:0]     grant;
  logic           accept;
  logic           win_id;
  logic [N-1:0]   sel_opa;
  logic [N-1:0]   sel_opb;
  logic [M-1:0]   sel_cmd;
  logic [3:0]     sel_ctl;

  assign accept = (state_q == IDLE) && (|bus.REQ_VALID);
  assign win_id = grant[1];

  rr_arb2 u_arb (
    .clk     (CLK),
    .rst     (RST),
    .req     (bus.REQ_VALID),
    .advance (accept),
    .grant   (grant)
  );

  // Ready only goes to the winner while idle, and stays low during reset
  always_comb begin
    bus.REQ_READY = ((state_q == IDLE) && !RST) ? grant : 2'b00;
  end

  // Route the winning requester's operation toward the ALU registers
  always_comb begin
    sel_opa = win_id ? bus.REQ1_OPA : bus.REQ0_OPA;
    sel_opb = win_id ? bus.REQ1_OPB : bus.REQ0_OPB;
    sel_cmd = win_id ? bus.REQ1_CMD : bus.REQ0_CMD;
    sel_ctl = win_id ? bus.REQ1_CTL : bus.REQ0_CTL;
  end

  // Next-state logic for the accept / issue / wait / respond sequence
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    id_d            = id_q;
    alu_opa_d       = alu_opa_q;
    alu_opb_d       = alu_opb_q;
    alu_cmd_d       = alu_cmd_q;
    alu_mode_d      = alu_mode_q;
    alu_cin_d       = alu_cin_q;
    alu_ce_d        = alu_ce_q;
    alu_inp_valid_d = alu_inp_valid_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_id_d        = rsp_id_q;
    rsp_res_d       = rsp_res_q;
    rsp_flags_d     = rsp_flags_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_opa_d       = sel_opa;
          alu_opb_d       = sel_opb;
          alu_cmd_d       = sel_cmd;
          alu_mode_d      = sel_ctl[3];
          alu_cin_d       = sel_ctl[2];
          alu_inp_valid_d = sel_ctl[1:0];
          alu_ce_d        = 1'b1;
          id_d            = win_id;
          cnt_d           = is_mul(sel_ctl[3], sel_cmd) ? CNT_W'(MUL_LAT) : CNT_W'(LAT);
          state_d         = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          rsp_res_d   = bus.ALU_RES;
          rsp_flags_d = bus.ALU_FLAGS;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          alu_ce_d    = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      id_q            <= 1'b0;
      alu_opa_q       <= '0;
      alu_opb_q       <= '0;
      alu_cmd_q       <= '0;
      alu_mode_q      <= 1'b0;
      alu_cin_q       <= 1'b0;
      alu_ce_q        <= 1'b0;
      alu_inp_valid_q <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_id_q        <= 1'b0;
      rsp_res_q       <= '0;
      rsp_flags_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      id_q            <= id_d;
      alu_opa_q       <= alu_opa_d;
      alu_opb_q       <= alu_opb_d;
      alu_cmd_q       <= alu_cmd_d;
      alu_mode_q      <= alu_mode_d;
      alu_cin_q       <= alu_cin_d;
      alu_ce_q        <= alu_ce_d;
      alu_inp_valid_q <= alu_inp_valid_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_id_q        <= rsp_id_d;
      rsp_res_q       <= rsp_res_d;
      rsp_flags_q     <= rsp_flags_d;
    end
  end

  // Drive the interface from the registered state
  always_comb begin
    bus.ALU_OPA       = alu_opa_q;
    bus.ALU_OPB       = alu_opb_q;
    bus.ALU_CMD       = alu_cmd_q;
    bus.ALU_MODE      = alu_mode_q;
    bus.ALU_CIN       = alu_cin_q;
    bus.ALU_CE        = alu_ce_q;
    bus.ALU_INP_VALID = alu_inp_valid_q;
    bus.RSP_VALID     = rsp_valid_q;
    bus.RSP_ID        = rsp_id_q;
    bus.RSP_RES       = rsp_res_q;
    bus.RSP_FLAGS     = rsp_flags_q;
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        capture;

  // Saturating counters for grants per requester and error responses
  always_comb begin
    capture      = (state_q == WAIT) && (cnt_q <= CNT_W'(1));
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    err_cnt_d    = err_cnt_q;
    if (accept && !win_id && (grant_cnt0_q != 16'hFFFF)) begin
      grant_cnt0_d = grant_cnt0_q + 16'd1;
    end
    if (accept && win_id && (grant_cnt1_q != 16'hFFFF)) begin
      grant_cnt1_d = grant_cnt1_q + 16'd1;
    end
    if (capture && bus.ALU_FLAGS[ERR] && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Statistics registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign GRANT_CNT0 = grant_cnt0_q;
  assign GRANT_CNT1 = grant_cnt1_q;
  assign ERR_CNT    = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Testbench for alu_req_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-numbered transaction model.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int N       = 8;
  localparam int M       = 4;
  localparam int LAT     = 2;
  localparam int MUL_LAT = 3;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] cmd;
    logic [3:0] ctl;
  } op_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  alu_req_arbiter_if #(.N(N), .M(M)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, err_cnt;
`endif

  alu_req_arbiter #(.N(N), .M(M), .LAT(LAT), .MUL_LAT(MUL_LAT)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
`ifdef ALU_ARB_STATS_EN
    ,
    .GRANT_CNT0 (grant_cnt0),
    .GRANT_CNT1 (grant_cnt1),
    .ERR_CNT    (err_cnt)
`endif
  );

  // Behavioural ALU: returns {flags, result}
  function automatic logic [21:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] cmd, input logic [3:0] ctl);
    int ai;
    int bi;
    int r;
    logic [5:0] f;
    ai = int'(a);
    bi = int'(b);
    r  = 0;
    f  = 6'd0;
    if (ctl[1:0] == 2'b00) begin
      f[5] = 1'b1;
    end else if (ctl[3]) begin
      case (cmd)
        4'd0:  begin r = ai + bi; f[3] = (r > 255); end
        4'd1:  begin r = ai - bi; f[4] = (ai < bi); end
        4'd2:  begin r = ai + bi + int'(ctl[2]); f[3] = (r > 255); end
        4'd8:  begin f[2] = (ai > bi); f[1] = (ai == bi); f[0] = (ai < bi); end
        4'd9:  r = (ai + 1) * (bi + 1);
        4'd10: r = (ai * 2) * bi;
        default: f[5] = 1'b1;
      endcase
    end else begin
      case (cmd)
        4'd0:  r = ai & bi;
        4'd2:  r = ai | bi;
        4'd4:  r = ai ^ bi;
        default: f[5] = 1'b1;
      endcase
    end
    return {f, r[15:0]};
  endfunction

  // ALU stand-in driven from the arbiter's ALU pins
  always_comb begin
    logic [21:0] o;
    o = alu_ref(bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD,
                {bus.ALU_MODE, bus.ALU_CIN, bus.ALU_INP_VALID});
    bus.ALU_RES   = bus.ALU_CE ? o[15:0] : 16'd0;
    bus.ALU_FLAGS = bus.ALU_CE ? o[21:16] : 6'd0;
  end

  int total = 0;
  int bad   = 0;

  // Stimulus state
  logic [1:0] req_valid = 2'b00;
  op_t        req_op [2];
  logic       rsp_ready = 1'b0;

  // Transaction model
  int         cyc = 0;
  bit         busy = 1'b0;
  op_t        cur_op;
  int         cur_id = 0;
  int         rsp_cycle = 0;
  int         last_winner = 1;
  logic [1:0] last_accept = 2'b00;
  logic [1:0] dut_ready;
  int         gc [2];
  int         ec = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    bus.REQ_VALID = req_valid;
    bus.REQ0_OPA  = req_op[0].a;
    bus.REQ0_OPB  = req_op[0].b;
    bus.REQ0_CMD  = req_op[0].cmd;
    bus.REQ0_CTL  = req_op[0].ctl;
    bus.REQ1_OPA  = req_op[1].a;
    bus.REQ1_OPB  = req_op[1].b;
    bus.REQ1_CMD  = req_op[1].cmd;
    bus.REQ1_CTL  = req_op[1].ctl;
    bus.RSP_READY = rsp_ready;
  endtask

  function automatic op_t make_op(input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] cmd, input logic [3:0] ctl);
    op_t o;
    o.a = a; o.b = b; o.cmd = cmd; o.ctl = ctl;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    logic [3:0] cmds [6];
    cmds[0] = 4'd0; cmds[1] = 4'd1; cmds[2] = 4'd2;
    cmds[3] = 4'd8; cmds[4] = 4'd9; cmds[5] = 4'd10;
    o.a = 8'($urandom);
    o.b = 8'($urandom);
    if ($urandom_range(7) == 0) o.cmd = 4'($urandom_range(15));
    else                        o.cmd = cmds[$urandom_range(5)];
    o.ctl[3]   = 1'($urandom_range(1));
    o.ctl[2]   = 1'($urandom_range(1));
    o.ctl[1:0] = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b11;
    return o;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model
  task automatic eval_cycle();
    logic [1:0]  exp_ready;
    logic [21:0] exp_o;
    bit          rsp_due;
    int          win;
    int          lat;
    drive_inputs();
    #1;
    dut_ready = bus.REQ_READY;
    exp_ready = 2'b00;
    if (!busy) begin
      if (req_valid == 2'b11) exp_ready = (last_winner == 1) ? 2'b01 : 2'b10;
      else                    exp_ready = req_valid;
    end
    checkOutput("reqReady", bus.REQ_READY, exp_ready);
    rsp_due = busy && (cyc >= rsp_cycle);
    checkOutput("rspValid", bus.RSP_VALID, rsp_due);
    exp_o = alu_ref(cur_op.a, cur_op.b, cur_op.cmd, cur_op.ctl);
    if (rsp_due) begin
      checkOutput("rspId", bus.RSP_ID, cur_id);
      checkOutput("rspRes", bus.RSP_RES, exp_o[15:0]);
      checkOutput("rspFlags", bus.RSP_FLAGS, exp_o[21:16]);
      if (cyc == rsp_cycle && exp_o[21]) ec++;
    end
    checkOutput("aluCe", bus.ALU_CE, busy && !rsp_due);
    if (busy && !rsp_due) begin
      checkOutput("aluPins", {bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE,
                              bus.ALU_CIN, bus.ALU_INP_VALID}, cur_op);
    end
    last_accept = exp_ready;
    if (exp_ready != 2'b00) begin
      win         = int'(exp_ready[1]);
      cur_op      = req_op[win];
      cur_id      = win;
      lat         = (cur_op.ctl[3] && (cur_op.cmd == 4'd9 || cur_op.cmd == 4'd10)) ? MUL_LAT : LAT;
      rsp_cycle   = cyc + lat + 2;
      last_winner = win;
      busy        = 1'b1;
      gc[win]++;
    end else if (rsp_due && rsp_ready) begin
      busy = 1'b0;
    end
    cyc++;
    @(negedge CLK);
  endtask

  // Asynchronous reset pulse starting mid-cycle; checks outputs while held
  task automatic apply_reset();
    drive_inputs();
    #2;
    RST = 1'b1;
    #1;
    checkOutput("rstReqReady", bus.REQ_READY, 2'b00);
    checkOutput("rstRspValid", bus.RSP_VALID, 1'b0);
    checkOutput("rstRsp", {bus.RSP_ID, bus.RSP_RES, bus.RSP_FLAGS}, 0);
    checkOutput("rstAluCe", bus.ALU_CE, 1'b0);
    checkOutput("rstAluPins", {bus.ALU_OPA, bus.ALU_OPB, bus.ALU_CMD, bus.ALU_MODE,
                               bus.ALU_CIN, bus.ALU_INP_VALID}, 0);
    @(negedge CLK);
    RST         = 1'b0;
    busy        = 1'b0;
    last_winner = 1;
    last_accept = 2'b00;
    gc[0] = 0; gc[1] = 0; ec = 0;
  endtask

  task automatic drain();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (8) eval_cycle();
    rsp_ready = 1'b0;
  endtask

  // Single directed operation with fixed expected result and latency
  task automatic applyStimulus(input int id, input op_t o, input logic [15:0] exp_res,
                               input logic [5:0] exp_flags, input int exp_lat);
    req_valid = 2'b00;
    req_valid[id] = 1'b1;
    req_op[id] = o;
    rsp_ready = 1'b0;
    eval_cycle();
    req_valid = 2'b00;
    repeat (exp_lat + 1) eval_cycle();
    #1;
    checkOutput("dirRspValid", bus.RSP_VALID, 1'b1);
    checkOutput("dirRspRes", bus.RSP_RES, exp_res);
    checkOutput("dirRspFlags", bus.RSP_FLAGS, exp_flags);
    checkOutput("dirRspId", bus.RSP_ID, id);
    rsp_ready = 1'b1;
    eval_cycle();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int r0;
    int r1;
    int grants [4];
    gc[0] = 0; gc[1] = 0;
    req_op[0] = make_op(8'd10, 8'd20, ADD, 4'b1011);
    req_op[1] = make_op(8'd7, 8'd9, ADD, 4'b1011);
    cur_op    = req_op[0];

    // Reset with both requesters active
    req_valid = 2'b11;
    apply_reset();

    // Round-robin with both requesters permanently valid
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    n = 0; r0 = 0; r1 = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      eval_cycle();
      if (dut_ready[0]) r0++;
      if (dut_ready[1]) r1++;
      if (dut_ready != 2'b00) begin
        grants[n] = int'(dut_ready[1]);
        n++;
      end
    end
    checkOutput("rrCount", n, 4);
    if (n == 4) begin
      checkOutput("rrGrant0", grants[0], 0);
      checkOutput("rrGrant1", grants[1], 1);
      checkOutput("rrGrant2", grants[2], 0);
      checkOutput("rrGrant3", grants[3], 1);
    end
    checkOutput("rrPulses0", r0, 2);
    checkOutput("rrPulses1", r1, 2);
    drain();

    // Directed ADD, multiply and error cases
    applyStimulus(0, make_op(8'd10, 8'd20, ADD, 4'b1011), 16'd30, 6'd0, LAT);
    applyStimulus(1, make_op(8'd3, 8'd4, INC_MUL, 4'b1011), 16'd20, 6'd0, MUL_LAT);
    applyStimulus(0, make_op(8'd5, 8'd6, ADD, 4'b1000), 16'd0, 6'b100000, LAT);

    // Backpressure: response held for 5 cycles while both requesters wait
    req_valid = 2'b10;
    req_op[1] = make_op(8'd1, 8'd2, ADD, 4'b1011);
    rsp_ready = 1'b0;
    eval_cycle();
    req_valid = 2'b11;
    req_op[0] = make_op(8'd40, 8'd2, SUB, 4'b1011);
    repeat (LAT + 1) eval_cycle();
    repeat (5) eval_cycle();
    rsp_ready = 1'b1;
    eval_cycle();
    #1;
    checkOutput("grantAfterDrain", bus.REQ_READY, 2'b01);
    drain();

    // Reset while the operation is waiting on the ALU
    req_valid = 2'b01;
    req_op[0] = make_op(8'd100, 8'd100, ADD, 4'b1011);
    eval_cycle();
    req_valid = 2'b00;
    repeat (2) eval_cycle();
    req_valid = 2'b11;
    apply_reset();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (6) eval_cycle();
    req_valid = 2'b11;
    eval_cycle();
    checkOutput("grantAfterReset", dut_ready, 2'b01);
    drain();

    // Random traffic
    last_accept = 2'b00;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && last_accept[i]) begin
          req_valid[i] = 1'($urandom_range(1));
          req_op[i] = rand_op();
        end else if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_op[i] = rand_op();
        end else if (req_valid[i] && $urandom_range(15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(2) != 0);
      eval_cycle();
    end
    drain();

`ifdef ALU_ARB_STATS_EN
    checkOutput("grantCnt0", grant_cnt0, gc[0]);
    checkOutput("grantCnt1", grant_cnt1, gc[1]);
    checkOutput("errCnt", err_cnt, ec);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
